// File: rtl/aes_cipher_iter_128.sv
// Iterative AES-128 encryption core: one round per clock, valid/ready on both sides.
// Consumes the eleven round keys from aes_key_expand_128 unregistered.

module sbox (
  input  logic [7:0] in,
  output logic [7:0] out
);

  // Row i of the table holds S(16*i) .. S(16*i+15); entry x sits at bits [(255-x)*8 +: 8].
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] w_idx;

  assign w_idx = {8'd255 - in, 3'b000};
  assign out   = SboxTable[w_idx +: 8];

endmodule

module aes_cipher_iter_128 #(
  parameter bit CLEAR_OUT = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] plaintext,
  input  logic [127:0] key_s0,
  input  logic [127:0] key_s1,
  input  logic [127:0] key_s2,
  input  logic [127:0] key_s3,
  input  logic [127:0] key_s4,
  input  logic [127:0] key_s5,
  input  logic [127:0] key_s6,
  input  logic [127:0] key_s7,
  input  logic [127:0] key_s8,
  input  logic [127:0] key_s9,
  input  logic [127:0] key_s10,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ciphertext
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRound = 2'd1,
    StDone  = 2'd2
  } state_e;

  state_e       r_fsm, w_fsm_nxt;
  logic [3:0]   r_rnd, w_rnd_nxt;
  logic [127:0] r_state, w_state_nxt;
  logic [127:0] r_ct, w_ct_nxt;
  logic         r_out_valid, w_out_valid_nxt;

  logic [127:0] w_sub, w_shift, w_mix, w_rkey, w_round;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    sbox u_sbox (
      .in  (r_state[127-8*n -: 8]),
      .out (w_sub[127-8*n -: 8])
    );
  end

  // Byte n is row n%4, column n/4; row r rotates left by r columns.
  always_comb begin
    w_shift = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        w_shift[127-8*(4*c+r) -: 8] = w_sub[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  always_comb begin
    w_mix = '0;
    for (int c = 0; c < 4; c++) begin
      w_mix[127-32*c -: 32] = mix_col(w_shift[127-32*c -: 32]);
    end
  end

  always_comb begin
    case (r_rnd)
      4'd1:    w_rkey = key_s1;
      4'd2:    w_rkey = key_s2;
      4'd3:    w_rkey = key_s3;
      4'd4:    w_rkey = key_s4;
      4'd5:    w_rkey = key_s5;
      4'd6:    w_rkey = key_s6;
      4'd7:    w_rkey = key_s7;
      4'd8:    w_rkey = key_s8;
      4'd9:    w_rkey = key_s9;
      4'd10:   w_rkey = key_s10;
      default: w_rkey = '0;
    endcase
  end

  // Final round drops MixColumns.
  assign w_round    = ((r_rnd == 4'd10) ? w_shift : w_mix) ^ w_rkey;
  assign in_ready   = (r_fsm == StIdle);
  assign out_valid  = r_out_valid;
  assign ciphertext = r_ct;

  always_comb begin
    w_fsm_nxt       = r_fsm;
    w_rnd_nxt       = r_rnd;
    w_state_nxt     = r_state;
    w_ct_nxt        = r_ct;
    w_out_valid_nxt = r_out_valid;
    case (r_fsm)
      StIdle: begin
        if (in_valid && in_ready) begin
          w_state_nxt = plaintext ^ key_s0;
          w_rnd_nxt   = 4'd1;
          w_fsm_nxt   = StRound;
        end
      end
      StRound: begin
        if (r_rnd >= 4'd1 && r_rnd <= 4'd10) begin
          w_state_nxt = w_round;
          if (r_rnd == 4'd10) begin
            w_rnd_nxt       = 4'd0;
            w_ct_nxt        = w_round;
            w_out_valid_nxt = 1'b1;
            w_fsm_nxt       = StDone;
          end else begin
            w_rnd_nxt = r_rnd + 4'd1;
          end
        end else begin
          w_rnd_nxt = 4'd0;
          w_fsm_nxt = StIdle;
        end
      end
      StDone: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (CLEAR_OUT) begin
            w_ct_nxt = '0;
          end
          w_fsm_nxt = StIdle;
        end
      end
      default: begin
        w_rnd_nxt = 4'd0;
        w_fsm_nxt = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_fsm       <= StIdle;
      r_rnd       <= '0;
      r_state     <= '0;
      r_ct        <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_fsm       <= w_fsm_nxt;
      r_rnd       <= w_rnd_nxt;
      r_state     <= w_state_nxt;
      r_ct        <= w_ct_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter_128.sv
// Self-checking bench for aes_cipher_iter_128: FIPS-197 vectors, handshake corner cases and
// random blocks against a byte-matrix AES reference model.

module tb_aes_cipher_iter_128;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] plaintext;
  logic [127:0] key_s [11];
  logic         in_ready, out_valid;
  logic [127:0] ct;
  logic         in_ready_c, out_valid_c;
  logic [127:0] ct_c;

  int n_chk = 0;
  int n_fail = 0;

  logic [7:0]   sb [256];
  logic [127:0] rk_m [11];

  always #5 clk = ~clk;

  aes_cipher_iter_128 #(.CLEAR_OUT(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .plaintext(plaintext),
    .key_s0(key_s[0]), .key_s1(key_s[1]), .key_s2(key_s[2]), .key_s3(key_s[3]),
    .key_s4(key_s[4]), .key_s5(key_s[5]), .key_s6(key_s[6]), .key_s7(key_s[7]),
    .key_s8(key_s[8]), .key_s9(key_s[9]), .key_s10(key_s[10]),
    .out_valid(out_valid), .out_ready(out_ready), .ciphertext(ct)
  );

  aes_cipher_iter_128 #(.CLEAR_OUT(1'b1)) u_dut_clr (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_c), .plaintext(plaintext),
    .key_s0(key_s[0]), .key_s1(key_s[1]), .key_s2(key_s[2]), .key_s3(key_s[3]),
    .key_s4(key_s[4]), .key_s5(key_s[5]), .key_s6(key_s[6]), .key_s7(key_s[7]),
    .key_s8(key_s[8]), .key_s9(key_s[9]), .key_s10(key_s[10]),
    .out_valid(out_valid_c), .out_ready(out_ready), .ciphertext(ct_c)
  );

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = xt(a);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      if (x == 0) inv = 8'h00;
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) begin
      rk_m[r]  = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      key_s[r] = rk_m[r];
    end
  endtask

  function automatic logic [7:0] mc_coef(input int r, input int k);
    int d;
    d = (k - r + 4) % 4;
    return (d == 0) ? 8'h02 : (d == 1) ? 8'h03 : 8'h01;
  endfunction

  function automatic logic [127:0] ref_encrypt(input logic [127:0] pt);
    logic [7:0]   s [4][4];
    logic [7:0]   t [4][4];
    logic [7:0]   acc;
    logic [127:0] res;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        s[r][c] = pt[127-8*(4*c+r) -: 8] ^ rk_m[0][127-8*(4*c+r) -: 8];
    for (int rd = 1; rd <= 10; rd++) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[r][c] = sb[s[r][(c+r)%4]];
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++) begin
          if (rd < 10) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gmul(mc_coef(r, k), t[k][c]);
          end else begin
            acc = t[r][c];
          end
          s[r][c] = acc ^ rk_m[rd][127-8*(4*c+r) -: 8];
        end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        res[127-8*(4*c+r) -: 8] = s[r][c];
    return res;
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [127:0] pt);
    check("accept_ready", 128'(in_ready), 128'd1);
    plaintext = pt;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  task automatic wait_out(input string tag, output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check(tag, 128'(out_valid), 128'd1);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("hs_valid_low", 128'(out_valid), 128'd0);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  localparam logic [127:0] KeyB = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PtB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CtB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] KeyC = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PtC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CtC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  initial begin
    int           lat;
    int           idx, done, cyc;
    int           acc_cyc [4];
    logic         acc, hs;
    logic [127:0] pts [4];
    logic [127:0] exps [4];
    logic [127:0] pt_r, exp_r;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; plaintext = '0;
    for (int i = 0; i < 11; i++) key_s[i] = '0;
    build_sbox();
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_in_ready", 128'(in_ready), 128'd1);
    check("rst_out_valid", 128'(out_valid), 128'd0);
    check("rst_ct", ct, 128'd0);

    // App.B with latency measurement and backpressure
    set_key(KeyB);
    start(PtB);
    lat = 0;
    while (!out_valid && lat < 40) begin
      check("busy_in_ready", 128'(in_ready), 128'd0);
      tick();
      lat++;
    end
    check("appB_latency", 128'(lat), 128'd10);
    check("appB_ct", ct, CtB);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_out_valid", 128'(out_valid), 128'd1);
      check("bp_ct", ct, CtB);
      check("bp_in_ready", 128'(in_ready), 128'd0);
    end
    handshake();
    check("hs_in_ready", 128'(in_ready), 128'd1);
    check("hs_ct_hold", ct, CtB);
    check("hs_ct_clear", ct_c, 128'd0);

    // Busy input pulse at round 4 is ignored
    start(PtB);
    tick(); tick(); tick();
    plaintext = rand128();
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    plaintext = PtB;
    wait_out("busy_timeout", lat);
    check("busy_ct", ct, CtB);
    handshake();

    // Reset mid-encryption, then App.C.1
    set_key(KeyC);
    start(rand128());
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 128'(out_valid), 128'd0);
    check("midrst_ct", ct, 128'd0);
    check("midrst_in_ready", 128'(in_ready), 128'd1);
    tick();
    check("midrst_hold", 128'(out_valid), 128'd0);
    start(PtC);
    wait_out("appC_timeout", lat);
    check("appC_latency", 128'(lat), 128'd10);
    check("appC_ct", ct, CtC);
    handshake();

    // Random keys and plaintexts against the model
    for (int b = 0; b < 4; b++) begin
      set_key(rand128());
      pt_r  = rand128();
      exp_r = ref_encrypt(pt_r);
      start(pt_r);
      wait_out("rand_timeout", lat);
      check("rand_ct", ct, exp_r);
      handshake();
    end

    // Streaming: in_valid and out_ready held high for four blocks
    set_key(rand128());
    for (int i = 0; i < 4; i++) begin
      pts[i]  = rand128();
      exps[i] = ref_encrypt(pts[i]);
    end
    plaintext = pts[0]; in_valid = 1'b1; out_ready = 1'b1;
    idx = 0; done = 0; cyc = 0;
    while (done < 4 && cyc < 100) begin
      acc = in_valid && in_ready;
      hs  = out_valid && out_ready;
      tick();
      cyc++;
      if (acc) begin
        acc_cyc[idx] = cyc;
        idx++;
        if (idx < 4) plaintext = pts[idx];
        else in_valid = 1'b0;
      end
      if (hs) begin
        check("stream_clr_after_hs", ct_c, 128'd0);
        check("stream_ready_after_hs", 128'(in_ready), 128'd1);
        done++;
      end
      if (out_valid && done < 4) begin
        check("stream_ct", ct, exps[done]);
        check("stream_ct_clr_dut", ct_c, exps[done]);
      end
    end
    out_ready = 1'b0;
    check("stream_blocks", 128'(done), 128'd4);
    for (int i = 1; i < 4; i++) check("stream_spacing", 128'(acc_cyc[i] - acc_cyc[i-1]), 128'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
